// File: rtl/reg_file_rdwb.sv
// reg_file_rdwb: operand fetch, busy-bit reservation and writeback.
// Build option REGFILE_WB_BYPASS_EN forwards same-cycle writebacks to sources.
module reg_file_rdwb #(
  parameter int NREGS = 20,
  parameter int VAL_W = 70
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_src_a,
  input  logic [7:0]       req_src_b,
  input  logic [7:0]       req_dst,
  input  logic [63:0]      req_rip,
  input  logic [63:0]      req_imm,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [VAL_W-1:0] rsp_a,
  output logic [VAL_W-1:0] rsp_b,
  output logic             rsp_err,
  input  logic             wb_valid,
  input  logic [7:0]       wb_dst,
  input  logic [VAL_W-1:0] wb_val,
  output logic [NREGS-1:0] busy
);

  localparam int IW = $clog2(NREGS);

  typedef logic [VAL_W-1:0] val_t;
  typedef logic [IW-1:0]    idx_t;

  function automatic logic is_real(input logic [7:0] id);
    return id[7] && (id[6:0] < 7'(NREGS));
  endfunction

  function automatic idx_t idx_of(input logic [7:0] id);
    return id[IW-1:0];
  endfunction

  // {err, value} for one source; flags of fake registers are zero.
  function automatic logic [VAL_W:0] fetch(
    input logic [7:0]  id,
    input logic        real_id,
    input val_t        ent,
    input logic [63:0] rip,
    input logic [63:0] imm
  );
    logic [VAL_W:0] r;
    r = '0;
    if (real_id) begin
      r[VAL_W-1:0] = ent;
    end else begin
      unique case (id)
        8'h00:   r = '0;
        8'h01:   r[63:0] = rip;
        8'h02:   r[63:0] = imm;
        8'h03:   r = '0;
        8'h04:   r[63:0] = 64'd8;
        default: r[VAL_W] = 1'b1;
      endcase
    end
    return r;
  endfunction

  val_t rf [NREGS];

  logic a_real, b_real, d_real, w_real;
  idx_t a_i, b_i, d_i, w_i;
  logic a_hit, b_hit, d_hit;
  val_t ent_a, ent_b;
  logic [VAL_W:0] res_a, res_b;
  logic raw, waw, free, accept;
  logic [NREGS-1:0] busy_nxt;

  assign a_real = is_real(req_src_a);
  assign b_real = is_real(req_src_b);
  assign d_real = is_real(req_dst);
  assign w_real = wb_valid && is_real(wb_dst);
  assign a_i    = idx_of(req_src_a);
  assign b_i    = idx_of(req_src_b);
  assign d_i    = idx_of(req_dst);
  assign w_i    = idx_of(wb_dst);

`ifdef REGFILE_WB_BYPASS_EN
  assign a_hit = w_real && (wb_dst == req_src_a);
  assign b_hit = w_real && (wb_dst == req_src_b);
  assign d_hit = w_real && (wb_dst == req_dst);
`else
  assign a_hit = 1'b0;
  assign b_hit = 1'b0;
  assign d_hit = 1'b0;
`endif

  assign ent_a = a_hit ? wb_val : (a_real ? rf[a_i] : '0);
  assign ent_b = b_hit ? wb_val : (b_real ? rf[b_i] : '0);
  assign res_a = fetch(req_src_a, a_real, ent_a, req_rip, req_imm);
  assign res_b = fetch(req_src_b, b_real, ent_b, req_rip, req_imm);

  assign raw = (a_real && busy[a_i] && !a_hit)
            || (b_real && busy[b_i] && !b_hit);
  assign waw = d_real && busy[d_i] && !d_hit;

  assign free      = !rsp_valid || rsp_ready;
  assign req_ready = free && !raw && !waw;
  assign accept    = req_valid && req_ready;

  // Writeback releases, accept reserves; reserve wins on a tie.
  always_comb begin
    busy_nxt = busy;
    if (w_real) busy_nxt[w_i] = 1'b0;
    if (accept && d_real) busy_nxt[d_i] = 1'b1;
  end

  // Reservation bits.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  // Register entries, written only by writeback to a real id.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (w_real) begin
      rf[w_i] <= wb_val;
    end
  end

  // Single-entry response register; holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_a     <= '0;
      rsp_b     <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_a     <= res_a[VAL_W-1:0];
      rsp_b     <= res_b[VAL_W-1:0];
      rsp_err   <= res_a[VAL_W] | res_b[VAL_W];
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_rdwb.sv
// tb_reg_file_rdwb: directed checks of reg_file_rdwb with a response scoreboard.
// Honours REGFILE_WB_BYPASS_EN to pick the expected stall timing.
module tb_reg_file_rdwb;

  localparam int NREGS = 20;
  localparam int VAL_W = 70;

  typedef logic [VAL_W-1:0] val_t;
  typedef struct packed {
    val_t a;
    val_t b;
    logic err;
  } rsp_t;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_src_a;
  logic [7:0]       req_src_b;
  logic [7:0]       req_dst;
  logic [63:0]      req_rip;
  logic [63:0]      req_imm;
  logic             rsp_valid;
  logic             rsp_ready;
  val_t             rsp_a;
  val_t             rsp_b;
  logic             rsp_err;
  logic             wb_valid;
  logic [7:0]       wb_dst;
  val_t             wb_val;
  logic [NREGS-1:0] busy;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   w;

  reg_file_rdwb #(.NREGS(NREGS), .VAL_W(VAL_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src_a(req_src_a), .req_src_b(req_src_b),
    .req_dst(req_dst), .req_rip(req_rip), .req_imm(req_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_err(rsp_err),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_val(wb_val),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cf is the top flag bit, then zf,sf,of,pf,af, then the 64-bit value.
  function automatic val_t fl(input logic cf, input logic [63:0] v);
    return {cf, 5'b0, v};
  endfunction

  task automatic chk(input string tag, input val_t obs, input val_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a uop, wait (bounded) for req_ready, record its expected response.
  task automatic issue(
    input logic [7:0]  a, b, d,
    input logic [63:0] rip, imm,
    input val_t        ea, eb,
    input logic        eerr,
    input int          budget,
    output int         waited
  );
    req_valid = 1'b1;
    req_src_a = a;
    req_src_b = b;
    req_dst   = d;
    req_rip   = rip;
    req_imm   = imm;
    waited    = 0;
    for (;;) begin
      @(negedge clk);
      if (req_ready) begin
        sb.push_back('{a: ea, b: eb, err: eerr});
        break;
      end
      if (waited >= budget) begin
        n_checks++;
        n_err++;
        $error("FAIL accept_timeout observed=stalled expected=accepted");
        break;
      end
      waited++;
      tick();
    end
    tick();
    req_valid = 1'b0;
  endtask

  // Every transfer is compared against the oldest expected response.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      rsp_t e;
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $error("FAIL rsp_unexpected observed=%0h expected=none", rsp_a);
      end else begin
        e = sb.pop_front();
        chk("rsp_a", rsp_a, e.a);
        chk("rsp_b", rsp_b, e.b);
        chk("rsp_err", val_t'(rsp_err), val_t'(e.err));
      end
    end
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_src_a = '0;
    req_src_b = '0;
    req_dst   = '0;
    req_rip   = '0;
    req_imm   = '0;
    rsp_ready = 1'b1;
    wb_valid  = 1'b0;
    wb_dst    = '0;
    wb_val    = '0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_busy", val_t'(busy), '0);
    chk("rst_rsp_valid", val_t'(rsp_valid), '0);
    chk("rst_rsp_a", rsp_a, '0);
    chk("rst_rsp_b", rsp_b, '0);
    chk("rst_rsp_err", val_t'(rsp_err), '0);
    tick();
    reset = 1'b0;

    // rv8 / rimm sources, no destination.
    issue(8'h04, 8'h02, 8'h00, 64'h0, 64'h1234,
          fl(0, 64'd8), fl(0, 64'h1234), 1'b0, 0, w);
    chk("t1_wait", val_t'(w), '0);
    @(negedge clk);
    chk("t1_busy", val_t'(busy), '0);
    tick();

    // Reserve rax, write it back, read it.
    issue(8'h00, 8'h00, 8'h80, 64'h0, 64'h0, '0, '0, 1'b0, 0, w);
    @(negedge clk);
    chk("t2_busy_set", val_t'(busy), val_t'(20'h1));
    tick();
    tick();
    wb_valid = 1'b1;
    wb_dst   = 8'h80;
    wb_val   = fl(1, 64'hDEAD);
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("t2_busy_clr", val_t'(busy), '0);
    tick();
    issue(8'h80, 8'h03, 8'h00, 64'h0, 64'h0,
          fl(1, 64'hDEAD), '0, 1'b0, 0, w);
    chk("t2_wait", val_t'(w), '0);
    tick();

    // RAW on rcx resolved by writeback.
    issue(8'h00, 8'h00, 8'h82, 64'h0, 64'h0, '0, '0, 1'b0, 0, w);
    req_valid = 1'b1;
    req_src_a = 8'h82;
    req_src_b = 8'h00;
    req_dst   = 8'h00;
    @(negedge clk);
    chk("t3_stall0", val_t'(req_ready), '0);
    tick();
    wb_valid = 1'b1;
    wb_dst   = 8'h82;
    wb_val   = fl(0, 64'd5);
    @(negedge clk);
`ifdef REGFILE_WB_BYPASS_EN
    chk("t3_bypass_ready", val_t'(req_ready), val_t'(1'b1));
    sb.push_back('{a: fl(0, 64'd5), b: '0, err: 1'b0});
    tick();
    wb_valid  = 1'b0;
    req_valid = 1'b0;
`else
    chk("t3_stall1", val_t'(req_ready), '0);
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("t3_ready", val_t'(req_ready), val_t'(1'b1));
    sb.push_back('{a: fl(0, 64'd5), b: '0, err: 1'b0});
    tick();
    req_valid = 1'b0;
`endif
    @(negedge clk);
    chk("t3_busy", val_t'(busy), '0);
    tick();
    tick();

    // Back-pressure: output holds, second uop waits, then goes same cycle.
    rsp_ready = 1'b0;
    issue(8'h01, 8'h04, 8'h00, 64'h111, 64'h0,
          fl(0, 64'h111), fl(0, 64'd8), 1'b0, 0, w);
    req_valid = 1'b1;
    req_src_a = 8'h02;
    req_src_b = 8'h00;
    req_dst   = 8'h00;
    req_rip   = 64'h0;
    req_imm   = 64'h222;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_ready_lo", val_t'(req_ready), '0);
      chk("t4_hold_a", rsp_a, fl(0, 64'h111));
      chk("t4_hold_b", rsp_b, fl(0, 64'd8));
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_ready_hi", val_t'(req_ready), val_t'(1'b1));
    sb.push_back('{a: fl(0, 64'h222), b: '0, err: 1'b0});
    tick();
    req_valid = 1'b0;
    tick();

    // Unmapped sources; writeback to a fake id is ignored.
    wb_valid = 1'b1;
    wb_dst   = 8'h02;
    wb_val   = fl(1, 64'hABC);
    issue(8'h95, 8'h05, 8'h00, 64'h0, 64'h0, '0, '0, 1'b1, 0, w);
    wb_valid = 1'b0;
    @(negedge clk);
    chk("t5_busy", val_t'(busy), '0);
    tick();
    issue(8'h80, 8'h82, 8'h00, 64'h0, 64'h0,
          fl(1, 64'hDEAD), fl(0, 64'd5), 1'b0, 0, w);
    chk("t5_wait", val_t'(w), '0);
    tick();

    // Write to non-busy rax, then src == dst.
    wb_valid = 1'b1;
    wb_dst   = 8'h80;
    wb_val   = fl(0, 64'h77);
    tick();
    wb_valid = 1'b0;
    issue(8'h80, 8'h80, 8'h80, 64'h0, 64'h0,
          fl(0, 64'h77), fl(0, 64'h77), 1'b0, 0, w);
    @(negedge clk);
    chk("t6_busy_rax", val_t'(busy), val_t'(20'h1));
    tick();

    // Reserve and release rdx in the same cycle: reserve wins.
    wb_valid = 1'b1;
    wb_dst   = 8'h83;
    wb_val   = fl(0, 64'h99);
    issue(8'h00, 8'h00, 8'h83, 64'h0, 64'h0, '0, '0, 1'b0, 0, w);
    wb_valid = 1'b0;
    @(negedge clk);
    chk("t6_set_wins", val_t'(busy), val_t'(20'h9));
    tick();
    req_valid = 1'b1;
    req_src_a = 8'h00;
    req_src_b = 8'h00;
    req_dst   = 8'h83;
    @(negedge clk);
    chk("t6_waw", val_t'(req_ready), '0);
    tick();
    req_valid = 1'b0;
    wb_valid  = 1'b1;
    wb_dst    = 8'h80;
    wb_val    = fl(0, 64'h1);
    tick();
    wb_dst = 8'h83;
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("t6_release", val_t'(busy), '0);
    tick();

    // Reset while rbx is reserved and a response is stalled.
    rsp_ready = 1'b0;
    issue(8'h00, 8'h00, 8'h81, 64'h0, 64'h0, '0, '0, 1'b0, 0, w);
    @(negedge clk);
    chk("t7_busy_rbx", val_t'(busy), val_t'(20'h2));
    chk("t7_rsp_valid", val_t'(rsp_valid), val_t'(1'b1));
    tick();
    sb.delete();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t7_rst_busy", val_t'(busy), '0);
    chk("t7_rst_valid", val_t'(rsp_valid), '0);
    chk("t7_rst_a", rsp_a, '0);
    tick();
    issue(8'h81, 8'h80, 8'h00, 64'h0, 64'h0, '0, '0, 1'b0, 0, w);
    chk("t7_wait", val_t'(w), '0);
    tick();
    tick();

    chk("sb_drained", val_t'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
